mux3_rr_scheduler: RTL and testbench
====================================

Name: mux3_rr_scheduler

Overview:
- Round-robin scheduler that shares one downstream datapath unit (e.g. the float-to-fixed linearizer stage) between three requesters.
- Drives the 2-bit select of the 3:1 operand mux placed in front of that unit, issues a one-cycle start to the unit, waits for its done, then acknowledges the winning requester.
- Sits between the three operand sources and the mux/unit pair in the linearizer/normalizer path.

Parameters:
- TMO_CYC, 255, WAIT_DONE cycles before abort (used only with the optional feature).
- CW, 8, width of the timeout counter; TMO_CYC must be <= 2^CW-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  request per source; requester holds it high until its ack
- done_unit  in  1  one-cycle pulse from the shared unit, result ready
- ctrl  out  2  mux select: 00=D0, 01=D1, 10=D2, 11=idle (mux outputs 0)
- gnt  out  3  one-hot grant, held for the whole transaction
- beg_unit  out  1  one-cycle start pulse to the shared unit
- ack  out  3  one-hot, one-cycle completion pulse to the winner
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle timeout pulse; constant 0 without the macro

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous, active-high.
- All outputs are registered. Reset values:
  - state=IDLE, ctrl=2'b11, gnt=0, beg_unit=0, ack=0, busy=0, err=0.
  - Last-served pointer = 2, so source 0 has first priority after reset.
- FSM states: IDLE, LOAD, WAIT_DONE, RELEASE.
- IDLE:
  - If req != 0, pick the winner round-robin, searching last+1, last+2, last+3 (mod 3).
  - Go to LOAD. ctrl <= winner index, gnt <= onehot(winner).
  - If req == 0, stay in IDLE.
- LOAD (1 cycle):
  - beg_unit=1, ctrl/gnt stable. Go to WAIT_DONE.
  - done_unit is ignored in this cycle.
- WAIT_DONE:
  - Hold ctrl and gnt.
  - On done_unit=1, go to RELEASE.
  - req changes are ignored; a dropped request still completes.
- RELEASE (1 cycle):
  - ack[winner]=1, gnt=0, ctrl=2'b11.
  - Pointer <= winner. Go to IDLE.
- Latency:
  - req high in IDLE at cycle N: gnt, ctrl and beg_unit valid at N+1.
  - done_unit at cycle M: ack at M+1, IDLE at M+2.
  - Earliest next grant is M+3.
- Fairness: with all three requests held continuously, grants rotate 0,1,2,0,...
- A single requester may be served back-to-back.
- done_unit outside WAIT_DONE is ignored.
- Reset mid-transaction:
  - Everything returns to reset values immediately; no ack is issued.
  - The requester must re-arbitrate.

Optional Feature:
- Macro MUX3_SCHED_TIMEOUT_EN.
- Defined:
  - A CW-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TMO_CYC with no done_unit, go to RELEASE with err=1 and ack=0.
  - gnt is cleared and the pointer still advances to the winner.
  - done_unit arriving in the same cycle as the timeout wins: normal ack, err=0.
- Not defined: no counter is built, err is tied to 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, WAIT_DONE=2'd2, RELEASE=2'd3.
  - Select codes SEL_D0/D1/D2/IDLE = 2'b00/01/10/11.
- Sub-module rr_pick3 (combinational):
  - Inputs: req[2:0] and last[1:0].
  - Outputs: winner[1:0] and valid.
  - Reused by other shared-unit schedulers in the design.

Test Plan:
- Reset release, then req=3'b010 at cycle 5:
  - Cycle 6: ctrl=01, gnt=010, beg_unit=1.
  - done_unit at cycle 10: ack=010 at cycle 11, ctrl=11 at cycle 11.
- req=3'b111 held, with done_unit 3 cycles after each beg_unit:
  - Grant order 0,1,2,0.
  - Each ack is one-cycle and one-hot; busy low for exactly one cycle between transactions.
- req[0] dropped in WAIT_DONE, then done_unit:
  - ack=001 is still issued.
  - The next grant follows round-robin from pointer 0.
- rst asserted asynchronously mid-WAIT_DONE (between edges):
  - ctrl=11, gnt=0, busy=0 immediately.
  - After release, source 0 has priority again.
- With MUX3_SCHED_TIMEOUT_EN and TMO_CYC=4, no done_unit:
  - err pulses 4 cycles after entering WAIT_DONE; ack stays 000.
  - done_unit arriving exactly at the timeout cycle instead gives ack and err=0.
- done_unit pulses while in IDLE and LOAD: no ack, no state change.

Source files
------------

// File: rtl/mux3_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux3_rr_scheduler_pkg
//  Purpose  : Shared types, state encoding, mux select codes and helpers for
//             the three-way round-robin shared-unit scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package mux3_rr_scheduler_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  // Operand mux select codes; SEL_IDLE forces the mux output to zero
  localparam logic [1:0] SEL_D0   = 2'b00;
  localparam logic [1:0] SEL_D1   = 2'b01;
  localparam logic [1:0] SEL_D2   = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  // Pointer value after reset: makes source 0 the first candidate
  localparam logic [1:0] RST_LAST = 2'd2;

  // Next source index in the ring 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Source index to one-hot request/grant vector
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Source index to operand mux select code
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      2'd0:    sel = SEL_D0;
      2'd1:    sel = SEL_D1;
      2'd2:    sel = SEL_D2;
      default: sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux3_rr_scheduler_rr_pick3.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick3
//  Purpose  : Combinational three-way round-robin picker. Searches the
//             sources last+1, last+2, last+3 (mod 3) and returns the first
//             one requesting. Shared by the shared-unit schedulers.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick3
  import mux3_rr_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] cand3;

  // Priority search starting just after the last-served source
  always_comb begin
    cand1  = rr_next(last);
    cand2  = rr_next(cand1);
    cand3  = rr_next(cand2);
    winner = 2'd0;
    valid  = 1'b0;
    if ((req & onehot3(cand1)) != 3'b000) begin
      winner = cand1;
      valid  = 1'b1;
    end else if ((req & onehot3(cand2)) != 3'b000) begin
      winner = cand2;
      valid  = 1'b1;
    end else if ((req & onehot3(cand3)) != 3'b000) begin
      winner = cand3;
      valid  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux3_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mux3_rr_scheduler
//  Purpose  : Round-robin scheduler sharing one datapath unit between three
//             requesters: drives the 3:1 operand mux select, pulses the unit
//             start, waits for done and acknowledges the winner.
//             Optional WAIT_DONE timeout enabled by MUX3_SCHED_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mux3_rr_scheduler
  import mux3_rr_scheduler_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done_unit,
  output logic [1:0] ctrl,
  output logic [2:0] gnt,
  output logic       beg_unit,
  output logic [2:0] ack,
  output logic       busy,
  output logic       err
);

  // Reject timeout settings the counter cannot represent
  if (TMO_CYC < 1 || TMO_CYC > (2 ** CW) - 1) begin : g_bad_cfg
    $error("mux3_rr_scheduler: TMO_CYC must be in 1 .. 2^CW-1");
  end

  state_t     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] last_q, last_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [2:0] gnt_q, gnt_d;
  logic       beg_q, beg_d;
  logic [2:0] ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       err_d;

  logic [1:0] pick_win;
  logic       pick_vld;

  rr_pick3 u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_win),
    .valid  (pick_vld)
  );

`ifdef MUX3_SCHED_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
  logic          tmo_hit;

  // Counter is zero outside WAIT_DONE, so it is cleared on every entry
  always_comb begin
    cnt_d   = (state_q == WAIT_DONE) ? cnt_q + CW'(1) : '0;
    tmo_hit = (state_q == WAIT_DONE) && (cnt_q == TMO_LAST);
  end

  // Timeout counter and error pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    ctrl_d  = ctrl_q;
    gnt_d   = gnt_q;
    beg_d   = 1'b0;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOAD;
          win_d   = pick_win;
          ctrl_d  = sel_code(pick_win);
          gnt_d   = onehot3(pick_win);
          beg_d   = 1'b1;
        end
      end
      LOAD: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done in the timeout cycle takes precedence over the abort
        if (done_unit) begin
          state_d = RELEASE;
          ack_d   = onehot3(win_q);
          gnt_d   = 3'b000;
          ctrl_d  = SEL_IDLE;
        end else if (tmo_hit) begin
          state_d = RELEASE;
          err_d   = 1'b1;
          gnt_d   = 3'b000;
          ctrl_d  = SEL_IDLE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = SEL_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction without ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      last_q  <= RST_LAST;
      ctrl_q  <= SEL_IDLE;
      gnt_q   <= 3'b000;
      beg_q   <= 1'b0;
      ack_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      ctrl_q  <= ctrl_d;
      gnt_q   <= gnt_d;
      beg_q   <= beg_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ctrl     = ctrl_q;
  assign gnt      = gnt_q;
  assign beg_unit = beg_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux3_rr_scheduler
//  Purpose  : Self-checking bench for mux3_rr_scheduler. Expected acks are
//             queued when done_unit is driven and matched by an ack monitor.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux3_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       done_unit;
  logic [1:0] ctrl;
  logic [2:0] gnt;
  logic       beg_unit;
  logic [2:0] ack;
  logic       busy;
  logic       err;

  int         n_chk;
  int         n_fail;
  logic [2:0] exp_q[$];
  logic [1:0] m_last;

`ifdef MUX3_SCHED_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  mux3_rr_scheduler #(.TMO_CYC(TMO), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done_unit (done_unit),
    .ctrl      (ctrl),
    .gnt       (gnt),
    .beg_unit  (beg_unit),
    .ack       (ack),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin search: last+1, last+2, last+3 (mod 3)
  function automatic logic [1:0] m_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    idx = last;
    for (int i = 0; i < 3; i++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (r[idx]) return idx;
    end
    return 2'd3;
  endfunction

  // Ack monitor: every ack pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && ack !== 3'b000) begin
      if (exp_q.size() == 0) chk("ack_unexpected", {5'd0, ack}, 8'd0);
      else                   chk("ack", {5'd0, ack}, {5'd0, exp_q.pop_front()});
    end
  end

  // One full transaction starting from an IDLE cycle; wd = WAIT_DONE cycles
  task automatic run_txn(input logic [2:0] r, input int wd, input bit drop);
    logic [1:0] w;
    logic [2:0] oh;
    w   = m_pick(r, m_last);
    oh  = 3'b001 << w;
    req = r;
    tick();
    chk("beg_load", {7'd0, beg_unit}, 8'd1);
    chk("gnt_load", {5'd0, gnt}, {5'd0, oh});
    chk("ctrl_load", {6'd0, ctrl}, {6'd0, w});
    chk("busy_load", {7'd0, busy}, 8'd1);
    for (int k = 1; k <= wd; k++) begin
      tick();
      if (k == 1) chk("beg_off", {7'd0, beg_unit}, 8'd0);
      if (k == 1 && drop) req = r & ~oh;
      if (k == wd) begin
        done_unit = 1'b1;
        exp_q.push_back(oh);
      end
    end
    tick();
    done_unit = 1'b0;
    chk("ctrl_rel", {6'd0, ctrl}, 8'd3);
    chk("gnt_rel", {5'd0, gnt}, 8'd0);
    chk("busy_rel", {7'd0, busy}, 8'd1);
    chk("err_rel", {7'd0, err}, 8'd0);
    m_last = w;
    tick();
    chk("busy_idle", {7'd0, busy}, 8'd0);
    chk("ack_idle", {5'd0, ack}, 8'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = 3'b000;
    done_unit = 1'b0;
    m_last    = 2'd2;
    tick();
    tick();
    chk("rst_ctrl", {6'd0, ctrl}, 8'd3);
    chk("rst_gnt", {5'd0, gnt}, 8'd0);
    chk("rst_beg", {7'd0, beg_unit}, 8'd0);
    chk("rst_ack", {5'd0, ack}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    rst = 1'b0;
    tick();
    tick();

    // Single requester 1, done after four WAIT_DONE cycles
    run_txn(3'b010, 4, 1'b0);
    req = 3'b000;

    // Asynchronous reset in the middle of WAIT_DONE: no ack, state cleared
    req = 3'b100;
    tick();
    chk("mid_gnt", {5'd0, gnt}, 8'h04);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", {6'd0, ctrl}, 8'd3);
    chk("arst_gnt", {5'd0, gnt}, 8'd0);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    req = 3'b000;
    tick();
    rst    = 1'b0;
    m_last = 2'd2;
    tick();

    // All requests held: fairness 0,1,2,0 with done three cycles after start
    for (int t = 0; t < 4; t++) run_txn(3'b111, 3, 1'b0);
    chk("rr_ptr", {6'd0, m_last}, 8'd0);

    // Source 0 drops its request during WAIT_DONE; it still completes
    run_txn(3'b001, 2, 1'b1);
    run_txn(3'b111, 1, 1'b0);
    req = 3'b000;

    // done_unit in IDLE and in LOAD is ignored
    done_unit = 1'b1;
    tick();
    done_unit = 1'b0;
    chk("done_idle_busy", {7'd0, busy}, 8'd0);
    chk("done_idle_ctrl", {6'd0, ctrl}, 8'd3);
    req = 3'b100;
    tick();
    chk("dl_beg", {7'd0, beg_unit}, 8'd1);
    done_unit = 1'b1;
    tick();
    done_unit = 1'b0;
    chk("dl_busy", {7'd0, busy}, 8'd1);
    chk("dl_gnt", {5'd0, gnt}, 8'h04);
    chk("dl_ctrl", {6'd0, ctrl}, 8'd2);
    tick();
    done_unit = 1'b1;
    exp_q.push_back(3'b100);
    tick();
    done_unit = 1'b0;
    chk("dl_rel_ctrl", {6'd0, ctrl}, 8'd3);
    m_last = 2'd2;
    req    = 3'b000;
    tick();
    chk("dl_idle_busy", {7'd0, busy}, 8'd0);

`ifdef MUX3_SCHED_TIMEOUT_EN
    // Timeout without done: err after TMO WAIT_DONE cycles, no ack
    req = 3'b001;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("tmo_wait_err", {7'd0, err}, 8'd0);
    end
    tick();
    chk("tmo_err", {7'd0, err}, 8'd1);
    chk("tmo_ack", {5'd0, ack}, 8'd0);
    chk("tmo_gnt", {5'd0, gnt}, 8'd0);
    chk("tmo_ctrl", {6'd0, ctrl}, 8'd3);
    m_last = 2'd0;
    req    = 3'b000;
    tick();
    chk("tmo_err_off", {7'd0, err}, 8'd0);
    chk("tmo_busy", {7'd0, busy}, 8'd0);

    // done_unit exactly in the timeout cycle wins
    req = 3'b001;
    tick();
    tick();
    tick();
    tick();
    tick();
    done_unit = 1'b1;
    exp_q.push_back(3'b001);
    tick();
    done_unit = 1'b0;
    chk("tmo_race_err", {7'd0, err}, 8'd0);
    req = 3'b000;
    tick();
`endif

    tick();
    chk("sb_empty", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
